mips16_wb_trace_fifo: RTL and testbench
=======================================

# mips16_wb_trace_fifo

Commit-trace buffer sitting directly downstream of the MIPS16 write-back stage. Every architectural register write (`reg_write_en` / `reg_write_dest` / `reg_write_data`) is captured with its PC and a commit sequence number. Captured writes are queued in a first-word-fall-through FIFO and handed to the verification bench through a valid/ready port. This decouples scoreboard checking from pipeline timing, and lost commits are made explicit instead of silent.

## Interface
Parameters:
- `DEPTH`, 8: number of trace entries; power of two, 2..64.
- `PC_W`, 8: PC width; matches `PC_WIDTH` of the core.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `reg_write_en`  in  1  WB stage is writing the register file this cycle.
- `reg_write_dest`  in  3  WB destination register number.
- `reg_write_data`  in  16  WB write data.
- `wb_pc`  in  PC_W  PC of the instruction in WB.
- `trace_valid`  out  1  head entry available.
- `trace_ready`  in  1  consumer accepts head entry.
- `trace_dest`  out  3  head entry destination register.
- `trace_data`  out  16  head entry data.
- `trace_pc`  out  PC_W  head entry PC.
- `trace_seq`  out  16  head entry commit sequence number.
- `trace_count`  out  $clog2(DEPTH)+1  entries currently held.
- `overflow`  out  1  sticky: a commit was dropped.
- `drop_count`  out  8  dropped commits, saturating.
- `overflow_clr`  in  1  clears `overflow` and `drop_count`.

## Operation
- Qualifying commit: `reg_write_en`=1, further filtered per Configuration.
- Every qualifying commit is tagged with the internal sequence counter `seq`, which then increments by 1 mod 2^16.
- `seq` increments on dropped commits too, so gaps in `trace_seq` identify lost entries.
- Push: a qualifying commit is written at the tail when the FIFO is not full.
  - When full, the commit is still accepted if a pop occurs in the same cycle.
- Pop: `trace_valid && trace_ready` at a rising edge advances the head.
- Drop: a qualifying commit while full with no simultaneous pop is discarded.
  - `overflow` is set and `drop_count` increments, saturating at 255.
- `overflow_clr`: clears `overflow` and `drop_count` next edge.
  - If a drop occurs in the same cycle, the drop wins: `overflow`=1 and `drop_count`=1.
- Head outputs are read from storage at the head pointer.
  - `trace_valid` = (`trace_count` != 0).
  - `trace_dest`/`trace_data`/`trace_pc`/`trace_seq` are don't-care while `trace_valid`=0.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally; full/empty are decided by `trace_count`.
- Simultaneous push and pop: `trace_count` unchanged, both pointers advance.
- `trace_ready` while empty is ignored.

## Timing
- Reset (`rst`=0, asynchronous): `trace_valid`=0, `trace_count`=0, `overflow`=0, `drop_count`=0, `seq`=0, pointers 0.
  - Head data outputs are 0 after reset.
  - Storage contents are not reset.
- Reset asserted mid-operation discards all entries immediately; no partial pop or push completes.
- Latency: a commit sampled at edge N appears at `trace_valid` after edge N (cycle N+1) when the FIFO was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle, sustained.
- Once asserted, `trace_valid` stays high and head data stays stable until popped; reset is the only exception.
- `trace_count` updates on the same edge as the push or pop.

## Configuration
- Macro `MIPS16_TRACE_R0_FILTER_EN`.
- Defined: writes with `reg_write_dest`=0 are not qualifying (R0 is hardwired zero). They are neither stored nor counted, and `seq` is not incremented.
- Undefined: every `reg_write_en`=1 cycle is qualifying, including dest 0.

## Test plan
- Reset then a single commit (dest 3, data 16'hBEEF, pc 8'h10) with `trace_ready`=0 → next cycle `trace_valid`=1, dest 3, data BEEF, pc 10, seq 0, count 1.
- Eight back-to-back commits, then `trace_ready`=1 → entries pop in order with seq 0..7; `trace_valid` drops after the 8th pop; count returns to 0.
- Fill to 8 and keep `trace_ready`=0, then commit 3 more → `overflow`=1, `drop_count`=3; the next commit accepted after one pop has seq 11.
- Full FIFO, commit with `trace_ready`=1 in the same cycle → no drop, count stays 8, `overflow` stays 0.
- Drop coinciding with `overflow_clr` → `overflow`=1, `drop_count`=1. A later `overflow_clr` alone → both 0.
- Commit to dest 0 → with macro: count unchanged and seq not advanced. Without macro: entry stored with dest 0.
- Assert `rst` low with 5 entries held → `trace_valid`=0 and `trace_count`=0 immediately; the first post-reset commit has seq 0.

Source files
------------

// File: rtl/mips16_wb_trace_fifo.sv
// mips16_wb_trace_fifo
// Commit-trace buffer placed after the MIPS16 write-back stage. Each
// register-file write is tagged with its PC and a 16-bit commit sequence
// number, then queued in a first-word-fall-through FIFO. The consumer
// drains it through a valid/ready port. Commits that find the FIFO full
// are dropped, but they still use up a sequence number, so each loss is
// visible as a gap in trace_seq.
//
// Ports:
//   clk, rst                 core clock; asynchronous active-low reset
//   reg_write_en/dest/data   write-back register write
//   wb_pc                    PC of the instruction in write-back
//   trace_valid/ready        head-entry handshake
//   trace_dest/data/pc/seq   head entry fields (0 while trace_valid=0)
//   trace_count              number of entries currently held
//   overflow, drop_count     sticky drop flag and saturating drop counter
//   overflow_clr             clears overflow and drop_count
//
// Optional feature: define MIPS16_TRACE_R0_FILTER_EN so that writes to R0
// are ignored. Such writes are neither stored nor counted, and they do not
// advance the sequence number.
module mips16_wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write_en,
    input  logic [2:0]               reg_write_dest,
    input  logic [15:0]              reg_write_data,
    input  logic [PC_W-1:0]          wb_pc,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [2:0]               trace_dest,
    output logic [15:0]              trace_data,
    output logic [PC_W-1:0]          trace_pc,
    output logic [15:0]              trace_seq,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 16 + PC_W + 16 + 3;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    seq_q, seq_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     drop_count_q, drop_count_d;

    logic qual, full, pop, push, drop;
    logic [EW-1:0] head;

    always_comb begin
`ifdef MIPS16_TRACE_R0_FILTER_EN
        qual = reg_write_en && (reg_write_dest != 3'd0);
`else
        qual = reg_write_en;
`endif
        full = (count_q == FULL_CNT);
        pop  = (count_q != '0) && trace_ready;
        // When the FIFO is full, a pop in the same cycle frees the slot
        // that this cycle's push needs.
        push = qual && (!full || pop);
        drop = qual && full && !pop;
    end

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        seq_d        = seq_q + 16'(qual);
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        // A drop in the same cycle as a clear takes priority, so the
        // counter restarts at 1 instead of losing that drop.
        if (drop) begin
            overflow_d   = 1'b1;
            if (overflow_clr)
                drop_count_d = 8'd1;
            else if (drop_count_q != 8'hFF)
                drop_count_d = drop_count_q + 8'd1;
        end else if (overflow_clr) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is not reset. Only the pointers and count decide which
    // entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {seq_q, wb_pc, reg_write_data, reg_write_dest};
    end

    // Masking by trace_valid makes the head fields read 0 after reset
    // while the storage still holds stale contents.
    assign head        = mem_q[rd_ptr_q];
    assign trace_valid = (count_q != '0);
    assign {trace_seq, trace_pc, trace_data, trace_dest} = trace_valid ? head : '0;
    assign trace_count = count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_mips16_wb_trace_fifo.sv
module tb_mips16_wb_trace_fifo;

    localparam int DEPTH = 8;
    localparam int PC_W  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_write_en = 1'b0;
    logic [2:0]  reg_write_dest = '0;
    logic [15:0] reg_write_data = '0;
    logic [7:0]  wb_pc = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [2:0]  trace_dest;
    logic [15:0] trace_data;
    logic [7:0]  trace_pc;
    logic [15:0] trace_seq;
    logic [3:0]  trace_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        overflow_clr = 1'b0;

    mips16_wb_trace_fifo #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .wb_pc(wb_pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_dest(trace_dest), .trace_data(trace_data),
        .trace_pc(trace_pc), .trace_seq(trace_seq),
        .trace_count(trace_count), .overflow(overflow),
        .drop_count(drop_count), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
        logic [7:0]  pc;
        logic [15:0] seq;
    } ent_t;

    // Reference model: a queue of entries plus the sequence counter and the
    // drop bookkeeping.
    ent_t m_q[$];
    int   m_seq;
    bit   m_ov;
    int   m_dc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(trace_valid), 32'(m_q.size() != 0));
        chk({tag, ".count"}, 32'(trace_count), 32'(m_q.size()));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(m_dc));
        if (m_q.size() != 0) begin
            chk({tag, ".dest"}, 32'(trace_dest), 32'(m_q[0].dest));
            chk({tag, ".data"}, 32'(trace_data), 32'(m_q[0].data));
            chk({tag, ".pc"},   32'(trace_pc),   32'(m_q[0].pc));
            chk({tag, ".seq"},  32'(trace_seq),  32'(m_q[0].seq));
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_seq = 0;
        m_ov  = 0;
        m_dc  = 0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then check
    // the outputs 1 time unit after the edge.
    task automatic step(input string tag, input bit en, input logic [2:0] dest,
                        input logic [15:0] data, input logic [7:0] pc,
                        input bit rdy, input bit clr);
        bit   qual, popped, dropped;
        ent_t e;
        reg_write_en   = en;
        reg_write_dest = dest;
        reg_write_data = data;
        wb_pc          = pc;
        trace_ready    = rdy;
        overflow_clr   = clr;
`ifdef MIPS16_TRACE_R0_FILTER_EN
        qual = en && (dest != 3'd0);
`else
        qual = en;
`endif
        @(posedge clk);
        #1;
        popped  = rdy && (m_q.size() != 0);
        if (popped) void'(m_q.pop_front());
        dropped = 0;
        if (qual) begin
            if (m_q.size() < DEPTH) begin
                e.dest = dest; e.data = data; e.pc = pc; e.seq = 16'(m_seq);
                m_q.push_back(e);
            end else begin
                dropped = 1;
            end
            m_seq = (m_seq + 1) % 65536;
        end
        if (dropped) begin
            m_ov = 1;
            m_dc = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
        end else if (clr) begin
            m_ov = 0;
            m_dc = 0;
        end
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        reg_write_en = 1'b0;
        trace_ready  = 1'b0;
        overflow_clr = 1'b0;
        #1;
        model_reset();
        chk({tag, ".rst_valid"}, 32'(trace_valid), 32'd0);
        chk({tag, ".rst_count"}, 32'(trace_count), 32'd0);
        chk({tag, ".rst_ov"},    32'(overflow), 32'd0);
        chk({tag, ".rst_dc"},    32'(drop_count), 32'd0);
        chk({tag, ".rst_data"},  32'(trace_data), 32'd0);
        chk({tag, ".rst_seq"},   32'(trace_seq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1, 3'(1 + (i % 7)), 16'($urandom), 8'($urandom), 0, 0);
    endtask

    initial begin
        // single commit, latency and head fields
        do_reset("r0");
        step("one", 1, 3'd3, 16'hBEEF, 8'h10, 0, 0);
        chk("one.valid_c", 32'(trace_valid), 32'd1);
        chk("one.data_c",  32'(trace_data), 32'hBEEF);
        chk("one.seq_c",   32'(trace_seq), 32'd0);

        // eight back-to-back commits drained in order
        do_reset("r1");
        fill("b2b", 8);
        chk("b2b.full_c", 32'(trace_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain.seq_c", 32'(trace_seq), 32'(i));
            step("drain", 0, 3'd0, 16'd0, 8'd0, 1, 0);
        end
        chk("drain.empty_c", 32'(trace_valid), 32'd0);

        // three drops, then a commit after one pop carries seq 11
        do_reset("r2");
        fill("ovf", 8);
        fill("ovf_drop", 3);
        chk("ovf.ov_c", 32'(overflow), 32'd1);
        chk("ovf.dc_c", 32'(drop_count), 32'd3);
        step("ovf_pop", 0, 3'd0, 16'd0, 8'd0, 1, 0);
        step("ovf_push", 1, 3'd5, 16'h1234, 8'h44, 0, 0);
        for (int i = 0; i < 7; i++) step("ovf_drain", 0, 3'd0, 16'd0, 8'd0, 1, 0);
        chk("ovf.seq11_c", 32'(trace_seq), 32'd11);

        // full with a simultaneous pop: no drop
        do_reset("r3");
        fill("fp", 8);
        step("fp_push_pop", 1, 3'd2, 16'hAAAA, 8'h22, 1, 0);
        chk("fp.count_c", 32'(trace_count), 32'd8);
        chk("fp.ov_c", 32'(overflow), 32'd0);

        // a drop in the same cycle as a clear wins, then a clear alone
        fill("clr_drop", 2);
        step("drop_clr", 1, 3'd4, 16'h5555, 8'h33, 0, 1);
        chk("drop_clr.dc_c", 32'(drop_count), 32'd1);
        step("clr_only", 0, 3'd0, 16'd0, 8'd0, 0, 1);
        chk("clr_only.ov_c", 32'(overflow), 32'd0);

        // drop_count saturates at 255
        for (int i = 0; i < 260; i++) step("sat", 1, 3'd1, 16'($urandom), 8'($urandom), 0, 0);
        chk("sat.dc_c", 32'(drop_count), 32'd255);

        // a write to R0
        do_reset("r4");
        step("r0w", 1, 3'd0, 16'hCAFE, 8'h55, 0, 0);
`ifdef MIPS16_TRACE_R0_FILTER_EN
        chk("r0w.count_c", 32'(trace_count), 32'd0);
        step("r0w_next", 1, 3'd6, 16'h0001, 8'h56, 0, 0);
        chk("r0w.seq_c", 32'(trace_seq), 32'd0);
`else
        chk("r0w.count_c", 32'(trace_count), 32'd1);
        chk("r0w.dest_c", 32'(trace_dest), 32'd0);
`endif

        // reset asserted mid-operation with 5 entries held
        do_reset("r5");
        fill("mid", 5);
        do_reset("r5b");
        step("post_rst", 1, 3'd7, 16'h7777, 8'h77, 0, 0);
        chk("post_rst.seq_c", 32'(trace_seq), 32'd0);

        // randomized traffic: slow consumer, then fast consumer
        for (int i = 0; i < 1500; i++) begin
            step("rnd", ($urandom_range(0, 9) < 7), 3'($urandom), 16'($urandom), 8'($urandom),
                 (i < 750) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
